// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Multi-cycle unsigned restoring divider. It retires one
//                quotient bit per clock, so an N-bit divide takes N cycles.
//                The FSM has three states: IDLE -> CALC -> DONE -> IDLE.
//                A zero divisor skips CALC and goes straight to DONE, with
//                quotient = all ones, remainder = dividend and div_by_zero set.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    N            operand, quotient and remainder width (even, >= 4)
//  Ports
//    clk          single clock; all state updates on its rising edge
//    rst_n        synchronous, active-low reset
//    start        request to begin a division; sampled only in IDLE
//    dividend     unsigned dividend, captured on the accepting edge
//    divisor      unsigned divisor, captured on the accepting edge
//    quotient     registered quotient; held from DONE until the next start
//    remainder    registered remainder; held from DONE until the next start
//    busy         high for exactly the N cycles spent in CALC
//    done         one-cycle pulse marking quotient/remainder/div_by_zero valid
//    div_by_zero  registered flag, set together with done for a zero divisor
// ============================================================================
module seq_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The step counter has to reach N-1, so size it for N to keep things simple.
    localparam int               c_CW   = $clog2(N + 1);
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(N - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [1:0]      w_state_next;

    logic [N-1:0]    r_divisor;   // divisor captured at the accepting edge
    logic [N-1:0]    r_dvd;       // dividend bits shift out the top; quotient bits shift in the bottom
    logic [N-1:0]    r_rem;       // partial remainder
    logic [c_CW-1:0] r_count;     // number of steps already completed

    // ------------------------------------------------------------------------
    // Decodes
    // ------------------------------------------------------------------------
    logic w_accept;               // start accepted on this edge
    logic w_zero_div;             // divisor input is zero
    logic w_last_step;            // this CALC edge performs step N

    assign w_accept    = (r_state == c_IDLE) && start;
    assign w_zero_div  = (divisor == '0);
    assign w_last_step = (r_state == c_CALC) && (r_count == c_LAST);

    // ------------------------------------------------------------------------
    // One restoring-division step
    // ------------------------------------------------------------------------
    // The shifted partial remainder needs N+1 bits. The invariant rem < divisor
    // keeps it below 2*divisor, so whichever value survives (the trial
    // difference or the restored value) always fits back into N bits.
    logic [N:0]   w_shift;
    logic [N:0]   w_trial;
    logic         w_fits;
    logic [N-1:0] w_rem_next;
    logic [N-1:0] w_dvd_next;

    assign w_shift    = {r_rem, r_dvd[N-1]};
    assign w_trial    = w_shift - {1'b0, r_divisor};
    assign w_fits     = ~w_trial[N];                 // trial >= 0
    assign w_rem_next = w_fits ? w_trial[N-1:0] : w_shift[N-1:0];
    assign w_dvd_next = {r_dvd[N-2:0], w_fits};

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // start is looked at only in IDLE. In CALC and DONE it is ignored, so a
    // start held high through DONE is taken on the first IDLE edge.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_next = w_zero_div ? c_DONE : c_CALC;
                end
            end
            c_CALC: begin
                if (w_last_step) begin
                    w_state_next = c_DONE;
                end
            end
            c_DONE: begin
                w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_CALC:  busy = 1'b1;
            c_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------------
    // quotient/remainder change only when a result is produced: on the
    // accepting edge for a zero divisor, otherwise on the final CALC edge.
    // So the last result stays visible through CALC and IDLE until a new
    // one replaces it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_divisor   <= '0;
            r_dvd       <= '0;
            r_rem       <= '0;
            r_count     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (w_accept) begin
                r_count     <= '0;
                div_by_zero <= w_zero_div;
                if (w_zero_div) begin
                    quotient  <= '1;
                    remainder <= dividend;
                end else begin
                    r_divisor <= divisor;
                    r_dvd     <= dividend;
                    r_rem     <= '0;
                end
            end else if (r_state == c_CALC) begin
                r_rem   <= w_rem_next;
                r_dvd   <= w_dvd_next;
                r_count <= r_count + c_CW'(1);
                if (w_last_step) begin
                    quotient  <= w_dvd_next;
                    remainder <= w_rem_next;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Self-checking bench for seq_divider (N = 32). A cycle-level
//                reference model uses plain / and % plus a latency countdown.
//                A compare process checks the DUT against that model on every
//                cycle. Directed cases add literal expectations, and 1000
//                random operations follow.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int N = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------------
    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    // After an accepted start with a nonzero divisor: busy for N cycles, then
    // done for one cycle showing a/b and a%b. A zero divisor gives done in
    // the very next cycle. The result is held until the next result arrives.
    logic         m_busy, m_done, m_dz;
    logic [N-1:0] m_q, m_r, m_a, m_b;
    int           m_wait;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            m_wait <= 0;
        end else if (m_busy) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_q    <= m_a / m_b;
                m_r    <= m_a % m_b;
            end
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (start) begin
            m_a <= dividend;
            m_b <= divisor;
            if (divisor == '0) begin
                m_done <= 1'b1;
                m_q    <= '1;
                m_r    <= dividend;
                m_dz   <= 1'b1;
            end else begin
                m_busy <= 1'b1;
                m_wait <= N;
                m_dz   <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-cycle compare, sampled on the falling edge
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {63'b0, busy}, {63'b0, m_busy});
            check("done", {63'b0, done}, {63'b0, m_done});
            check("div_by_zero", {63'b0, div_by_zero}, {63'b0, m_dz});
            if (!m_busy) begin
                check("quotient", 64'(quotient), 64'(m_q));
                check("remainder", 64'(remainder), 64'(m_r));
            end
            if (m_done && !m_dz) begin
                check("identity", 64'(quotient) * 64'(m_b) + 64'(remainder), 64'(m_a));
                check("rem_lt_div", {63'b0, (remainder < m_b)}, 64'd1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Run one operation. The caller is at a falling edge. The task waits gap
    // cycles, then raises start for one edge (edge k), optionally pulses
    // start again at edge k+inj, and returns at the falling edge where done
    // is seen. lat is the number of falling edges after edge k (-1 on
    // timeout); bcnt is the number of those cycles in which busy was high.
    // ------------------------------------------------------------------------
    task automatic op(input int gap, input logic [N-1:0] a, input logic [N-1:0] b,
                      input int inj, output int lat, output int bcnt);
        repeat (gap) @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat  = -1;
        bcnt = 0;
        for (int c = 1; c <= N + 8; c++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = c;
                break;
            end
            if (c == inj) begin
                start    = 1'b1;
                dividend = $urandom;
                divisor  = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    int           lat, bcnt, t1, t2, sel, inj;
    logic [N-1:0] ra, rb;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_quotient", 64'(quotient), 64'd0);
        check("rst_remainder", 64'(remainder), 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);

        // 100 / 7, started on the first edge after reset is released
        rst_n = 1'b1;
        op(0, 32'd100, 32'd7, 0, lat, bcnt);
        check("lat_100_7", 64'(lat), 64'(N + 1));
        check("busy_cycles_100_7", 64'(bcnt), 64'(N));
        check("q_100_7", 64'(quotient), 64'd14);
        check("r_100_7", 64'(remainder), 64'd2);
        check("dz_100_7", {63'b0, div_by_zero}, 64'd0);

        // Boundary operands
        op(1, 32'hFFFF_FFFF, 32'd1, 0, lat, bcnt);
        check("q_max_1", 64'(quotient), 64'hFFFF_FFFF);
        check("r_max_1", 64'(remainder), 64'd0);
        op(1, 32'd5, 32'd9, 0, lat, bcnt);
        check("q_5_9", 64'(quotient), 64'd0);
        check("r_5_9", 64'(remainder), 64'd5);

        // Divide by zero
        op(1, 32'h1234, 32'd0, 0, lat, bcnt);
        check("lat_div0", 64'(lat), 64'd1);
        check("busy_cycles_div0", 64'(bcnt), 64'd0);
        check("q_div0", 64'(quotient), 64'hFFFF_FFFF);
        check("r_div0", 64'(remainder), 64'h1234);
        check("dz_div0", {63'b0, div_by_zero}, 64'd1);

        // start pulsed at edge k+5 during CALC is ignored
        op(1, 32'd100, 32'd7, 5, lat, bcnt);
        check("lat_ignore_start", 64'(lat), 64'(N + 1));
        check("q_ignore_start", 64'(quotient), 64'd14);
        check("r_ignore_start", 64'(remainder), 64'd2);

        // Reset at edge k+10 during CALC aborts the operation
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        check("abort_q", 64'(quotient), 64'd0);
        check("abort_r", 64'(remainder), 64'd0);
        check("abort_dz", {63'b0, div_by_zero}, 64'd0);
        rst_n = 1'b1;
        op(0, 32'd1000, 32'd10, 0, lat, bcnt);
        check("lat_1000_10", 64'(lat), 64'(N + 1));
        check("q_1000_10", 64'(quotient), 64'd100);
        check("r_1000_10", 64'(remainder), 64'd0);

        // Back-to-back: start held high, one IDLE cycle between operations
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd77;
        divisor  = 32'd5;
        t1 = -1;
        for (int c = 1; c <= N + 8; c++) begin
            @(negedge clk);
            if (done) begin
                t1 = c;
                break;
            end
        end
        t2 = -1;
        for (int c = 1; c <= N + 8; c++) begin
            @(negedge clk);
            if (done) begin
                t2 = c;
                break;
            end
        end
        start = 1'b0;
        check("b2b_first_lat", 64'(t1), 64'(N + 1));
        check("b2b_gap", 64'(t2), 64'(N + 2));
        check("b2b_q", 64'(quotient), 64'd15);
        check("b2b_r", 64'(remainder), 64'd2);

        // Random operations
        for (int i = 0; i < 1000; i++) begin
            sel = $urandom_range(0, 9);
            ra  = (sel < 3) ? N'($urandom_range(0, 1000)) : N'($urandom);
            case (sel)
                0:       rb = '0;
                1, 2:    rb = N'($urandom_range(1, 15));
                3:       rb = 32'd1;
                4:       rb = ra;
                5:       rb = ra + 32'd1;
                6:       rb = '0;
                default: rb = N'($urandom);
            endcase
            inj = ($urandom_range(0, 3) == 0) ? $urandom_range(1, N + 1) : 0;
            op($urandom_range(1, 3), ra, rb, inj, lat, bcnt);
            check("rand_lat", 64'(lat), (rb == '0) ? 64'd1 : 64'(N + 1));
            check("rand_busy_cycles", 64'(bcnt), (rb == '0) ? 64'd0 : 64'(N));
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand, quotient and remainder width; legal values are even integers >= 4.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port dividend  input  N  unsigned dividend, captured on the accepting edge.
REQ-006 SHALL have port divisor  input  N  unsigned divisor, captured on the accepting edge.
REQ-007 SHALL have port quotient  output  N  registered unsigned quotient.
REQ-008 SHALL have port remainder  output  N  registered unsigned remainder.
REQ-009 SHALL have port busy  output  1  high while in CALC.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking that quotient and remainder are valid.
REQ-011 SHALL have port div_by_zero  output  1  registered flag set with done when the captured divisor was 0.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-013 SHALL stay in IDLE until an edge where start=1, which is the accepting edge; call it edge k.
REQ-014 SHALL, at edge k with divisor!=0, load the divisor, dividend shift register and partial remainder (cleared to 0), clear the iteration counter, clear div_by_zero and enter CALC.
REQ-015 SHALL perform one restoring-division step per CALC edge: shift {partial remainder, dividend} left by 1, compute trial = partial remainder - divisor at N+1 bits, keep trial and set the quotient LSB to 1 if trial >= 0, else restore and set the quotient LSB to 0.
REQ-016 SHALL complete exactly N steps on edges k+1 .. k+N, then enter DONE at edge k+N.
REQ-017 SHALL drive done=1 and present the final quotient and remainder for exactly the one cycle following edge k+N; at edge k+N+1 the FSM SHALL return to IDLE and done SHALL fall.
REQ-018 SHALL hold quotient, remainder and div_by_zero stable after DONE until the next accepted start.
REQ-019 SHALL, at edge k with divisor==0, skip CALC and enter DONE directly, with quotient = all ones, remainder = dividend and div_by_zero=1; done is then high in the cycle after edge k.
REQ-020 SHALL ignore start while in CALC or DONE, with no effect on the operation in progress.
REQ-021 SHALL drive busy=1 exactly in CALC and busy=0 in IDLE and DONE.
REQ-022 SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor for every nonzero divisor.
REQ-023 SHALL accept a start held continuously high in IDLE immediately after DONE, so that back-to-back operations run with one IDLE cycle between them.

Reset
REQ-024 SHALL, on any edge with rst_n=0, set state=IDLE, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0 and counter=0.
REQ-025 SHALL let reset override all other activity, including mid-CALC or in DONE, with no done pulse emitted for the aborted operation.
REQ-026 SHALL accept a start on the first edge after rst_n returns high.

Verification
REQ-027 SHALL cover N=32, dividend=100, divisor=7, start at edge k -> busy for edges k+1..k+32, done high in the cycle after edge k+32, quotient=14, remainder=2, div_by_zero=0.
REQ-028 SHALL cover dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0; and dividend=5, divisor=9 -> quotient=0, remainder=5.
REQ-029 SHALL cover dividend=0x1234, divisor=0 -> done in the cycle after edge k, busy never high, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
REQ-030 SHALL cover start pulsed at edge k+5 with new operands during CALC of 100/7 -> result still 14 rem 2 with done timing unchanged.
REQ-031 SHALL cover rst_n=0 at edge k+10 mid-CALC -> all outputs 0, no done; then start 1000/10 -> quotient=100, remainder=0.
REQ-032 SHALL cover 1000 random operand pairs (including divisor=0) checked against a reference model -> all results, flags and done timing match.
